lstm_sequencer: RTL and testbench

// Upstream driver for the single-step lstm cell. Accepts a config (seq length, h0, C0) and a

---
 rtl/lstm_pkg.sv | 14 +
 rtl/lstm_seq_fifo.sv | 53 +++++
 rtl/lstm_sequencer.sv | 170 +++++++++++++++++
 tb/tb_lstm_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM sequencer.
package lstm_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_ISSUE,
    SEQ_WAIT,
    SEQ_DRAIN
  } seq_state_t;

  // Cycles from x handshake to cell_valid on the single-step cell.
  localparam int unsigned CELL_LATENCY = 6;

endpackage

// File: rtl/lstm_seq_fifo.sv
// First-word-fall-through FIFO holding {last, y} results headed downstream.
module lstm_seq_fifo #(
  parameter int unsigned DW    = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DW-1:0]                push_data,
  input  logic                         pop,
  output logic [DW-1:0]                pop_data,
  output logic                         pop_valid,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // Pop only when data exists; a push into a full FIFO is allowed only alongside a pop.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  assign pop_data  = mem[rd_ptr];
  assign pop_valid = (count_q != '0);
  assign count     = count_q;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

  // Storage array; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/lstm_sequencer.sv
// Drives one LSTM cell step at a time over a configured sequence, buffering outputs.
module lstm_sequencer
  import lstm_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [WIDTH-1:0] cfg_h0,
  input  logic [WIDTH-1:0] cfg_c0,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic [WIDTH-1:0] s_x,
  input  logic             s_x_valid,
  output logic             s_x_ready,
  output logic [WIDTH-1:0] m_y,
  output logic             m_y_last,
  output logic             m_y_valid,
  input  logic             m_y_ready,
  output logic [WIDTH-1:0] final_h,
  output logic [WIDTH-1:0] final_c,
  input  logic             cell_ready,
  output logic [WIDTH-1:0] cell_x,
  output logic             cell_x_valid,
  output logic [WIDTH-1:0] cell_h,
  output logic             cell_h_valid,
  output logic [WIDTH-1:0] cell_c,
  output logic             cell_c_valid,
  input  logic [WIDTH-1:0] cell_y,
  input  logic [WIDTH-1:0] cell_c_out,
  input  logic             cell_valid
);

  localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] step_q;
  logic [WIDTH-1:0] h0_q;
  logic [WIDTH-1:0] c0_q;
  logic [TO_W-1:0]  wait_q;

  logic             issue_hs;
  logic             push;
  logic             latch_cfg;
  logic             done_d;
  logic             err_set;
  logic             last_step;
  logic [CNT_W-1:0] fifo_count;
  logic [WIDTH:0]   fifo_out;

  assign last_step = (step_q == (len_q - LEN_W'(1)));

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    s_x_ready = 1'b0;
    issue_hs  = 1'b0;
    push      = 1'b0;
    latch_cfg = 1'b0;
    done_d    = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (cfg_start) begin
          if (cfg_len != '0) begin
            latch_cfg = 1'b1;
            state_d   = SEQ_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEQ_ISSUE: begin
        s_x_ready = cell_ready && (fifo_count < CNT_W'(OUT_DEPTH));
        issue_hs  = s_x_valid && s_x_ready;
        if (issue_hs) state_d = SEQ_WAIT;
      end
      SEQ_WAIT: begin
        if (cell_valid) begin
          push    = 1'b1;
          state_d = last_step ? SEQ_DRAIN : SEQ_ISSUE;
        end else if (wait_q == TO_W'(TIMEOUT)) begin
          err_set = 1'b1;
          state_d = SEQ_IDLE;
        end
      end
      SEQ_DRAIN: begin
        if (fifo_count == '0) begin
          done_d  = 1'b1;
          state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= SEQ_IDLE;
    else     state_q <= state_d;
  end

  // Config latch, step/wait counters, status flags and final state capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      h0_q    <= '0;
      c0_q    <= '0;
      step_q  <= '0;
      wait_q  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      final_h <= '0;
      final_c <= '0;
    end else begin
      done <= done_d;
      if (latch_cfg) begin
        len_q  <= cfg_len;
        h0_q   <= cfg_h0;
        c0_q   <= cfg_c0;
        step_q <= '0;
        err    <= 1'b0;
      end
      if (err_set) err <= 1'b1;
      if (issue_hs)                   wait_q <= '0;
      else if (state_q == SEQ_WAIT)   wait_q <= wait_q + TO_W'(1);
      if (push) begin
        final_h <= cell_y;
        final_c <= cell_c_out;
        step_q  <= step_q + LEN_W'(1);
      end
    end
  end

  // Cell drive: x passes straight through on handshake; h0/C0 accompany step 0 only.
  assign cell_x       = s_x;
  assign cell_x_valid = issue_hs;
  assign cell_h       = h0_q;
  assign cell_c       = c0_q;
  assign cell_h_valid = issue_hs && (step_q == '0);
  assign cell_c_valid = issue_hs && (step_q == '0);
  assign busy         = (state_q != SEQ_IDLE);

  lstm_seq_fifo #(
    .DW    (WIDTH + 1),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({last_step, cell_y}),
    .pop       (m_y_ready),
    .pop_data  (fifo_out),
    .pop_valid (m_y_valid),
    .count     (fifo_count)
  );

  assign m_y      = fifo_out[WIDTH-1:0];
  assign m_y_last = fifo_out[WIDTH];

endmodule

// File: tb/tb_lstm_sequencer.sv
// Directed bench for lstm_sequencer with a behavioural single-step cell model.
module tb_lstm_sequencer;
  import lstm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [7:0]  cfg_len;
  logic [15:0] cfg_h0, cfg_c0;
  logic        busy, done, err;
  logic [15:0] s_x;
  logic        s_x_valid, s_x_ready;
  logic [15:0] m_y;
  logic        m_y_last, m_y_valid, m_y_ready;
  logic [15:0] final_h, final_c;
  logic        cell_ready;
  logic [15:0] cell_x, cell_h, cell_c;
  logic        cell_x_valid, cell_h_valid, cell_c_valid;
  logic [15:0] cell_y, cell_c_out;
  logic        cell_valid;
  logic        cell_mute;

  int n_checks = 0;
  int n_errors = 0;

  lstm_sequencer dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_len(cfg_len), .cfg_h0(cfg_h0), .cfg_c0(cfg_c0),
    .busy(busy), .done(done), .err(err),
    .s_x(s_x), .s_x_valid(s_x_valid), .s_x_ready(s_x_ready),
    .m_y(m_y), .m_y_last(m_y_last), .m_y_valid(m_y_valid), .m_y_ready(m_y_ready),
    .final_h(final_h), .final_c(final_c),
    .cell_ready(cell_ready),
    .cell_x(cell_x), .cell_x_valid(cell_x_valid),
    .cell_h(cell_h), .cell_h_valid(cell_h_valid),
    .cell_c(cell_c), .cell_c_valid(cell_c_valid),
    .cell_y(cell_y), .cell_c_out(cell_c_out), .cell_valid(cell_valid)
  );

  always #5 clk = ~clk;

  // Cell model: y = h + x, C_out = C + 1, result valid CELL_LATENCY cycles after issue.
  logic [15:0] h_fb, c_fb;
  int          pend;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h_fb <= '0; c_fb <= '0; cell_y <= '0; cell_c_out <= '0; pend <= 0;
    end else if (cell_x_valid && cell_ready) begin
      cell_y     <= (cell_h_valid ? cell_h : h_fb) + cell_x;
      h_fb       <= (cell_h_valid ? cell_h : h_fb) + cell_x;
      cell_c_out <= (cell_c_valid ? cell_c : c_fb) + 16'd1;
      c_fb       <= (cell_c_valid ? cell_c : c_fb) + 16'd1;
      pend       <= CELL_LATENCY;
    end else if (pend != 0) begin
      pend <= pend - 1;
    end
  end
  assign cell_valid = (pend == 1) && !cell_mute;

  // Event recorder sampling pre-edge values.
  int   cyc = 0, n_issue = 0, n_hv = 0, n_cv = 0, n_done = 0, pop_cyc = 0, done_cyc = 0;
  logic [15:0] y_q[$];
  logic        l_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cell_x_valid && cell_ready) n_issue <= n_issue + 1;
    if (cell_h_valid) n_hv <= n_hv + 1;
    if (cell_c_valid) n_cv <= n_cv + 1;
    if (m_y_valid && m_y_ready) begin
      y_q.push_back(m_y);
      l_q.push_back(m_y_last);
      pop_cyc <= cyc;
    end
    if (done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_cfg(input logic [7:0] len, input logic [15:0] h0, input logic [15:0] c0);
    cfg_len = len; cfg_h0 = h0; cfg_c0 = c0; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int i0, d0, yb, hv0;
    rst = 1'b1; cfg_start = 0; cfg_len = 0; cfg_h0 = 0; cfg_c0 = 0;
    s_x = 16'd256; s_x_valid = 0; m_y_ready = 0; cell_ready = 0; cell_mute = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_m_y_valid", m_y_valid, 0);
    check("rst_final_h", final_h, 0);
    check("rst_final_c", final_c, 0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: len=3, x=256, free-flowing output
    s_x_valid = 1; cell_ready = 1; m_y_ready = 1;
    i0 = n_issue; d0 = n_done; yb = y_q.size(); hv0 = n_hv;
    start_cfg(8'd3, 16'd0, 16'd0);
    check("t1_busy", busy, 1);
    check("t1_s_x_ready", s_x_ready, 1);
    check("t1_cell_h_valid", cell_h_valid, 1);
    check("t1_cell_c_valid", cell_c_valid, 1);
    for (int i = 0; i < 200 && n_done == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("t1_done_count", n_done - d0, 1);
    check("t1_issues", n_issue - i0, 3);
    check("t1_h_valid_once", n_hv - hv0, 1);
    check("t1_pops", y_q.size() - yb, 3);
    if (y_q.size() - yb == 3) begin
      check("t1_y0", y_q[yb], 256);
      check("t1_y1", y_q[yb+1], 512);
      check("t1_y2", y_q[yb+2], 768);
      check("t1_last0", l_q[yb], 0);
      check("t1_last1", l_q[yb+1], 0);
      check("t1_last2", l_q[yb+2], 1);
    end
    check("t1_final_h", final_h, 768);
    check("t1_final_c", final_c, 3);
    check("t1_done_after_pop", done_cyc - pop_cyc, 2);
    check("t1_busy_end", busy, 0);

    // Test 2: len=5 with downstream stalled until FIFO fills
    m_y_ready = 0;
    i0 = n_issue; d0 = n_done; yb = y_q.size();
    start_cfg(8'd5, 16'd0, 16'd0);
    for (int i = 0; i < 100 && (n_issue - i0) < 4; i++) @(negedge clk);
    repeat (12) @(negedge clk);
    check("t2_issues_full", n_issue - i0, 4);
    check("t2_s_x_ready_full", s_x_ready, 0);
    check("t2_m_y_valid", m_y_valid, 1);
    check("t2_m_y_head", m_y, 256);
    check("t2_busy", busy, 1);
    check("t2_no_done", n_done - d0, 0);
    m_y_ready = 1;
    for (int i = 0; i < 200 && n_done == d0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("t2_done_count", n_done - d0, 1);
    check("t2_issues", n_issue - i0, 5);
    check("t2_pops", y_q.size() - yb, 5);
    if (y_q.size() - yb == 5) begin
      check("t2_y4", y_q[yb+4], 1280);
      check("t2_last3", l_q[yb+3], 0);
      check("t2_last4", l_q[yb+4], 1);
    end
    check("t2_final_h", final_h, 1280);
    check("t2_final_c", final_c, 5);

    // Test 3: cell stops answering after the first step
    i0 = n_issue; d0 = n_done; yb = y_q.size();
    start_cfg(8'd3, 16'd0, 16'd0);
    for (int i = 0; i < 50 && (y_q.size() - yb) < 1; i++) @(negedge clk);
    cell_mute = 1;
    repeat (8) @(negedge clk);
    check("t3_err_early", err, 0);
    check("t3_busy_wait", busy, 1);
    for (int i = 0; i < 40 && !err; i++) @(negedge clk);
    check("t3_err", err, 1);
    check("t3_busy_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("t3_no_done", n_done - d0, 0);
    check("t3_issues", n_issue - i0, 2);
    check("t3_err_sticky", err, 1);
    cell_mute = 0;
    d0 = n_done;
    start_cfg(8'd1, 16'd0, 16'd0);
    check("t3_err_cleared", err, 0);
    check("t3_busy_restart", busy, 1);
    for (int i = 0; i < 100 && n_done == d0; i++) @(negedge clk);
    check("t3_restart_done", n_done - d0, 1);
    check("t3_restart_final_h", final_h, 256);

    // Test 4: zero-length sequence
    @(negedge clk);
    i0 = n_issue;
    start_cfg(8'd0, 16'd0, 16'd0);
    check("t4_done_pulse", done, 1);
    check("t4_busy", busy, 0);
    @(negedge clk);
    check("t4_done_clear", done, 0);
    check("t4_busy_after", busy, 0);
    check("t4_no_issue", n_issue - i0, 0);

    // Test 5: asynchronous reset during WAIT of step 2 of 4
    m_y_ready = 0;
    i0 = n_issue;
    start_cfg(8'd4, 16'd0, 16'd0);
    for (int i = 0; i < 60 && (n_issue - i0) < 2; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("t5_busy_pre", busy, 1);
    check("t5_m_y_valid_pre", m_y_valid, 1);
    rst = 1'b1;
    #1;
    check("t5_busy", busy, 0);
    check("t5_m_y_valid", m_y_valid, 0);
    check("t5_final_h", final_h, 0);
    check("t5_final_c", final_c, 0);
    check("t5_s_x_ready", s_x_ready, 0);
    check("t5_cell_x_valid", cell_x_valid, 0);
    check("t5_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_fifo_empty", m_y_valid, 0);

    // Test 6: cell not ready, restart attempt while busy is ignored
    m_y_ready = 1; cell_ready = 0;
    i0 = n_issue; d0 = n_done; yb = y_q.size();
    start_cfg(8'd2, 16'd100, 16'd10);
    repeat (5) @(negedge clk);
    check("t6_busy", busy, 1);
    check("t6_s_x_ready", s_x_ready, 0);
    check("t6_no_issue", n_issue - i0, 0);
    start_cfg(8'd5, 16'd0, 16'd0);
    check("t6_no_issue_after_start", n_issue - i0, 0);
    cell_ready = 1;
    for (int i = 0; i < 100 && n_done == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("t6_done_count", n_done - d0, 1);
    check("t6_issues", n_issue - i0, 2);
    check("t6_pops", y_q.size() - yb, 2);
    if (y_q.size() - yb == 2) check("t6_y0", y_q[yb], 356);
    check("t6_final_h", final_h, 612);
    check("t6_final_c", final_c, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
